// File: rtl/reg_dst_pipe.sv
// rtl/reg_dst_pipe.sv - destination-register select, write pipeline and RAW hazard detect
// Optional retired-write counter is built only when REG_DST_STATS_EN is defined.
module reg_dst_pipe #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        reg_dst,
    input  logic              reg_write_in,
    input  logic [ADDR_W-1:0] src_a_addr,
    input  logic [ADDR_W-1:0] src_b_addr,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [SW-1:0]     hazard_a_stage,
    output logic [SW-1:0]     hazard_b_stage,
    output logic [31:0]       wb_count
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [ADDR_W-1:0] sel_addr_raw;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;

    // Index 0 is stage 1 (youngest), index DEPTH-1 feeds write-back.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic              we_q   [DEPTH];
    logic              we_d   [DEPTH];

    logic [SW-1:0]     hz_a_stage;
    logic [SW-1:0]     hz_b_stage;

    always_comb begin
        sel_addr_raw = rt_addr;
        case (reg_dst)
            2'd0:    sel_addr_raw = rt_addr;
            2'd1:    sel_addr_raw = rd_addr;
            2'd2:    sel_addr_raw = LINK_ADDR;
            default: sel_addr_raw = '0;
        endcase
        sel_we   = reg_write_in && (reg_dst != 2'd3) && (sel_addr_raw != '0);
        sel_addr = sel_we ? sel_addr_raw : '0;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            addr_d[k] = addr_q[k];
            we_d[k]   = we_q[k];
        end
        if (stall) begin
            if (flush) begin
                addr_d[0] = '0;
                we_d[0]   = 1'b0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                addr_d[k] = addr_q[k-1];
                we_d[k]   = we_q[k-1];
            end
            addr_d[0] = flush ? '0 : sel_addr;
            we_d[0]   = flush ? 1'b0 : sel_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                we_q[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
                we_q[k]   <= we_d[k];
            end
        end
    end

    // Scan oldest to youngest so the youngest match is the value left standing.
    always_comb begin
        hz_a_stage = '0;
        hz_b_stage = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (we_q[k] && (addr_q[k] == src_a_addr) && (src_a_addr != '0))
                hz_a_stage = SW'(k + 1);
            if (we_q[k] && (addr_q[k] == src_b_addr) && (src_b_addr != '0))
                hz_b_stage = SW'(k + 1);
        end
    end

    assign hazard_a_stage = hz_a_stage;
    assign hazard_b_stage = hz_b_stage;
    assign hazard_a       = (hz_a_stage != '0);
    assign hazard_b       = (hz_b_stage != '0);

    assign wb_addr = addr_q[DEPTH-1];
    assign wb_we   = we_q[DEPTH-1];

`ifdef REG_DST_STATS_EN
    logic [31:0] wb_count_q;
    logic [31:0] wb_count_d;

    // A stalled write-back stage still writes the register file every cycle.
    assign wb_count_d = wb_we ? wb_count_q + 32'd1 : wb_count_q;

    always_ff @(posedge clk) begin
        if (reset)
            wb_count_q <= '0;
        else
            wb_count_q <= wb_count_d;
    end

    assign wb_count = wb_count_q;
`else
    assign wb_count = '0;
`endif

endmodule

// File: tb/tb_reg_dst_pipe.sv
// tb/tb_reg_dst_pipe.sv - randomized self-checking bench for reg_dst_pipe against a queue model
module tb_reg_dst_pipe;

    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 3;
    localparam int LINK_REG = 31;
    localparam int SW       = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset, stall, flush, reg_write_in;
    logic [ADDR_W-1:0] rt_addr, rd_addr, src_a_addr, src_b_addr;
    logic [1:0]        reg_dst;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_we, hazard_a, hazard_b;
    logic [SW-1:0]     hazard_a_stage, hazard_b_stage;
    logic [31:0]       wb_count;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    int   m_count = 0;

    reg_dst_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LINK_REG(LINK_REG)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .reg_dst(reg_dst),
        .reg_write_in(reg_write_in), .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .wb_addr(wb_addr), .wb_we(wb_we), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .hazard_a_stage(hazard_a_stage), .hazard_b_stage(hazard_b_stage),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    function automatic ent_t model_sel();
        ent_t e;
        int   a;
        a = (reg_dst == 2'd0) ? int'(rt_addr) : (reg_dst == 2'd1) ? int'(rd_addr) : LINK_REG;
        e.we   = reg_write_in && (reg_dst != 2'd3) && (a != 0);
        e.addr = e.we ? ADDR_W'(a) : '0;
        return e;
    endfunction

    // Youngest in-flight write to src, numbered from 1; 0 when none.
    function automatic int model_stage(logic [ADDR_W-1:0] src);
        if (src == 0) return 0;
        for (int i = 0; i < DEPTH; i++)
            if (q[i].we && q[i].addr == src) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef REG_DST_STATS_EN
        return 32'(m_count);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_edge();
        ent_t z;
        z = '0;
        if (reset) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(z);
            m_count = 0;
        end else begin
            if (q[DEPTH-1].we) m_count++;
            if (stall) begin
                if (flush) q[0] = z;
            end else begin
                q.push_front(flush ? z : model_sel());
                void'(q.pop_back());
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic [1:0] dst, input logic rw,
                          input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd);
        reg_dst = dst; reg_write_in = rw; rt_addr = rt; rd_addr = rd;
    endtask

    task automatic drain();
        stall = 0; flush = 0;
        set_in(2'd3, 1'b0, '0, '0);
        repeat (DEPTH) cycle();
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        set_in(2'd1, 1'b1, 5'd3, 5'd3);
        src_a_addr = 5'd3; src_b_addr = 5'd3;
        repeat (2) cycle();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%0b exp=0", wb_we); end
        checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_wb_addr got=%0d exp=0", wb_addr); end
        checks++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin errors++;
            $display("FAIL reset_hazard got=%0b%0b exp=00", hazard_a, hazard_b); end
        checks++; if (wb_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", wb_count); end
        reset = 0;
        drain();
    endtask

    task automatic test_select_latency();
        logic [ADDR_W-1:0] exp_a [3];
        exp_a[0] = 5'd9; exp_a[1] = 5'd4; exp_a[2] = 5'd31;
        src_a_addr = 0; src_b_addr = 0;
        set_in(2'd1, 1'b1, 5'd0, 5'd9);  cycle();
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lat_early got=%0b exp=0", wb_we); end
        set_in(2'd0, 1'b1, 5'd4, 5'd0);  cycle();
        set_in(2'd2, 1'b1, 5'd0, 5'd0);  cycle();
        set_in(2'd3, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wb_we !== 1'b1 || wb_addr !== exp_a[i]) begin errors++;
                $display("FAIL lat_wb%0d got=%0d/%0b exp=%0d/1", i, wb_addr, wb_we, exp_a[i]); end
            cycle();
        end
        checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lat_after got=%0b exp=0", wb_we); end
        drain();
    endtask

    task automatic test_suppression();
        src_a_addr = 5'd5; src_b_addr = 5'd6;
        set_in(2'd1, 1'b1, 5'd5, 5'd0); cycle();
        src_a_addr = 5'd0;
        checks++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin errors++;
            $display("FAIL sup_rd0_hazard got=%0b%0b exp=00", hazard_a, hazard_b); end
        src_a_addr = 5'd5;
        set_in(2'd3, 1'b1, 5'd5, 5'd6); cycle();
        checks++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin errors++;
            $display("FAIL sup_none_hazard got=%0b%0b exp=00", hazard_a, hazard_b); end
        set_in(2'd3, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wb_we !== 1'b0 || wb_addr !== '0) begin errors++;
                $display("FAIL sup_wb%0d got=%0d/%0b exp=0/0", i, wb_addr, wb_we); end
            cycle();
        end
    endtask

    task automatic test_hazard_priority();
        drain();
        set_in(2'd0, 1'b1, 5'd7, 5'd0); cycle();
        set_in(2'd3, 1'b0, 5'd0, 5'd0); cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd7); cycle();
        set_in(2'd3, 1'b0, 5'd0, 5'd0);
        src_a_addr = 5'd7; src_b_addr = 5'd0; #1;
        checks++; if (hazard_a !== 1'b1 || hazard_a_stage !== SW'(1)) begin errors++;
            $display("FAIL prio_young got=%0b/%0d exp=1/1", hazard_a, hazard_a_stage); end
        checks++; if (hazard_b !== 1'b0 || hazard_b_stage !== '0) begin errors++;
            $display("FAIL prio_src0 got=%0b/%0d exp=0/0", hazard_b, hazard_b_stage); end
        stall = 1; flush = 1; cycle();
        stall = 0; flush = 0;
        checks++; if (hazard_a !== 1'b1 || hazard_a_stage !== SW'(3)) begin errors++;
            $display("FAIL prio_old got=%0b/%0d exp=1/3", hazard_a, hazard_a_stage); end
        drain();
    endtask

    task automatic test_stall_flush();
        set_in(2'd1, 1'b1, 5'd0, 5'd10); cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd11); cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd5);  cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd20);
        src_a_addr = 5'd5; src_b_addr = 5'd11;
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (hazard_a_stage !== SW'(1) || hazard_b_stage !== SW'(2) || wb_addr !== 5'd10 || wb_we !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d got=%0d/%0d/%0d exp=1/2/10", i, hazard_a_stage, hazard_b_stage, wb_addr);
            end
        end
        flush = 1; cycle();
        checks++; if (hazard_a !== 1'b0 || hazard_a_stage !== '0) begin errors++;
            $display("FAIL sflush_a got=%0b/%0d exp=0/0", hazard_a, hazard_a_stage); end
        checks++; if (hazard_b_stage !== SW'(2) || wb_addr !== 5'd10 || wb_we !== 1'b1) begin errors++;
            $display("FAIL sflush_rest got=%0d/%0d exp=2/10", hazard_b_stage, wb_addr); end
        stall = 0; flush = 0;
        drain();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            stall        = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 5) == 0);
            reg_dst      = 2'($urandom_range(0, 3));
            reg_write_in = ($urandom_range(0, 3) != 0);
            rt_addr      = ADDR_W'($urandom_range(0, 7));
            rd_addr      = ADDR_W'($urandom_range(0, 7));
            src_a_addr   = ADDR_W'(($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7));
            src_b_addr   = ADDR_W'($urandom_range(0, 7));
            cycle();
            checks++;
            if (wb_addr !== q[DEPTH-1].addr || wb_we !== q[DEPTH-1].we ||
                hazard_a_stage !== SW'(model_stage(src_a_addr)) ||
                hazard_b_stage !== SW'(model_stage(src_b_addr)) ||
                hazard_a !== (model_stage(src_a_addr) != 0) ||
                hazard_b !== (model_stage(src_b_addr) != 0) ||
                wb_count !== exp_count()) begin
                errors++;
                if (bad++ < 8)
                    $display("FAIL rand%0d got wb=%0d/%0b hs=%0d/%0d cnt=%0d exp wb=%0d/%0b hs=%0d/%0d cnt=%0d",
                             n, wb_addr, wb_we, hazard_a_stage, hazard_b_stage, wb_count,
                             q[DEPTH-1].addr, q[DEPTH-1].we, model_stage(src_a_addr),
                             model_stage(src_b_addr), exp_count());
            end
        end
        stall = 0; flush = 0;
        drain();
    endtask

    task automatic test_stats();
        logic [1:0] dsts [6];
        logic       rws  [6];
        logic [31:0] exp_n;
        reset = 1; cycle(); reset = 0;
        dsts[0] = 2'd1; dsts[1] = 2'd1; dsts[2] = 2'd0; dsts[3] = 2'd2; dsts[4] = 2'd3; dsts[5] = 2'd1;
        rws[0]  = 1;    rws[1]  = 0;    rws[2]  = 1;    rws[3]  = 1;    rws[4]  = 1;    rws[5]  = 1;
        for (int i = 0; i < 6; i++) begin
            set_in(dsts[i], rws[i], 5'd12, 5'd13);
            cycle();
        end
        drain();
`ifdef REG_DST_STATS_EN
        exp_n = 32'd4;
`else
        exp_n = 32'd0;
`endif
        checks++; if (wb_count !== exp_n) begin errors++;
            $display("FAIL stats_count got=%0d exp=%0d", wb_count, exp_n); end
    endtask

    task automatic test_reset_midstream();
        set_in(2'd1, 1'b1, 5'd0, 5'd14); cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd15); cycle();
        set_in(2'd1, 1'b1, 5'd0, 5'd16);
        reset = 1; cycle(); reset = 0;
        set_in(2'd3, 1'b0, 5'd0, 5'd0);
        src_a_addr = 5'd15; src_b_addr = 5'd14; #1;
        checks++; if (wb_count !== 32'd0 || hazard_a !== 1'b0 || hazard_b !== 1'b0) begin errors++;
            $display("FAIL mrst_state got=%0d/%0b%0b exp=0/00", wb_count, hazard_a, hazard_b); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wb_we !== 1'b0) begin errors++; $display("FAIL mrst_wb%0d got=%0b exp=0", i, wb_we); end
            cycle();
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0;
        set_in(2'd3, 1'b0, '0, '0);
        src_a_addr = '0; src_b_addr = '0;
        test_reset();
        test_select_latency();
        test_suppression();
        test_hazard_priority();
        test_stall_flush();
        test_random();
        test_stats();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dst_pipe.md
Name: reg_dst_pipe

Overview:
- Parametrised successor to the 5-bit 2:1 write-register selector.
- Selects the destination register address from rt, rd, the link register or none, then carries it with its write-enable through a DEPTH-stage shift pipeline to the write-back port.
- Flags read-after-write hazards of two source addresses against every in-flight write, reporting the youngest matching stage.
- Sits between decode and the register file in the pipelined datapath.

Parameters:
ADDR_W, 5, register address width
DEPTH, 3, number of pipeline stages from select to write-back (>=1)
LINK_REG, 31, address forced when reg_dst selects link (jal)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold all stages
flush  input  1  squash the entry being captured into stage 1
rt_addr  input  ADDR_W  instruction rt field
rd_addr  input  ADDR_W  instruction rd field
reg_dst  input  2  0=rt, 1=rd, 2=LINK_REG, 3=no destination
reg_write_in  input  1  instruction writes a register
src_a_addr  input  ADDR_W  first source operand address
src_b_addr  input  ADDR_W  second source operand address
wb_addr  output  ADDR_W  write-back destination (last stage)
wb_we  output  1  write-back enable (last stage)
hazard_a  output  1  src_a matches a pending write
hazard_b  output  1  src_b matches a pending write
hazard_a_stage  output  SW  youngest matching stage for src_a, 0=none; SW=$clog2(DEPTH+1)
hazard_b_stage  output  SW  same for src_b
wb_count  output  32  retired-write counter (optional feature)

Behaviour:
- Select (combinational): sel_addr = rt/rd/LINK_REG per reg_dst. sel_we = reg_write_in & (reg_dst!=3) & (sel_addr!=0). When sel_we=0, sel_addr is forced to 0.
- Stages 1..DEPTH each hold {addr, we}. Stage DEPTH drives wb_addr/wb_we directly from registers; no combinational path from inputs.
- Each clk edge, evaluated in this order:
  - reset: all stages {0,0}, wb_count=0.
  - stall=1, flush=0: every stage holds.
  - stall=1, flush=1: stage 1 cleared to {0,0}; stages 2..DEPTH hold.
  - stall=0: stage k takes stage k-1. Stage 1 takes {sel_addr, sel_we}, or {0,0} if flush=1.
- Latency: with no stall/flush, a selection sampled at edge n appears on wb_* after edge n+DEPTH-1, i.e. DEPTH cycles of pipeline.
- Hazard (combinational from stage registers and src inputs):
  - Stage k matches src_x when stage_k.we=1, stage_k.addr==src_x and src_x!=0.
  - hazard_x = OR over all k. hazard_x_stage = smallest matching k (youngest), else 0.
  - A write in stage DEPTH still counts: the register file writes at the clock edge, so same-cycle reads are hazards.
- Address 0 never produces a write or a hazard.
- DEPTH=1: a single stage; hazard_x_stage width is 1.
- Reset mid-stream drops all in-flight writes; wb_we=0 on the cycle after the reset edge.

Optional Feature:
- Macro REG_DST_STATS_EN.
- Defined: wb_count increments by 1 on every clk edge where wb_we=1 and reset=0. Increments regardless of stall, since a held WB stage writes once per cycle per register-file semantics. Wraps at 2^32 to 0.
- Not defined: wb_count is constant 0 and no counter flops are built.

Test Plan:
- Reset: reset=1 for 2 cycles -> wb_we=0, wb_addr=0, hazard_a=hazard_b=0, wb_count=0.
- Select/latency, DEPTH=3: issue reg_dst=1 rd=9, then reg_dst=0 rt=4, then reg_dst=2 -> wb_addr 9, 4, 31 on consecutive cycles, each 3 cycles after issue, wb_we=1 each.
- Suppression: rd=0 with reg_dst=1, and reg_dst=3 with reg_write_in=1 -> wb_we=0, wb_addr=0, no hazards raised.
- Hazard priority: write to r7 in stage 3 and stage 1, src_a=7, src_b=0 -> hazard_a=1, hazard_a_stage=1, hazard_b=0. After stage 1 is flushed -> hazard_a_stage=3.
- Stall/flush: write to r5 in stage 1, stall=1 for 2 cycles -> r5 stays in stage 1. Then stall=1 with flush=1 -> stage 1 cleared, hazard on src_a=5 drops, stages 2..3 unchanged.
- Stats (REG_DST_STATS_EN): 4 writes and 2 bubbles retired -> wb_count=4. Reset mid-stream -> wb_count=0 and in-flight writes never reach wb_we.
